// File: rtl/if_prefetch_stage_if.sv
// Instruction memory request/response bus between the prefetch stage and memory.
// One request may be in flight; responses come back in order.
interface if_prefetch_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  memReq;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  memReady;
    logic                  memRvalid;
    logic [DATA_WIDTH-1:0] memRdata;

    modport master (output memReq, memAddr, input memReady, memRvalid, memRdata);
    modport slave  (input memReq, memAddr, output memReady, memRvalid, memRdata);
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch stage: fetches sequential words into a small FIFO and
// presents the head entry; a taken branch flushes the FIFO and retargets fetch.
module if_prefetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  brTaken,
    input  logic [ADDR_WIDTH-1:0] brBase,
    input  logic [ADDR_WIDTH-1:0] brOffset,
    input  logic                  freeze,
    if_prefetch_stage_if.master   mem,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] r_fpc;
    logic [ADDR_WIDTH-1:0] r_oaddr;
    logic                  r_outst;
    logic                  r_discard;
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_wptr;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] r_abuf [DEPTH];
    logic [DATA_WIDTH-1:0] r_dbuf [DEPTH];

    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;

    assign w_target = brBase + (brOffset << 2);

    // Only one request in flight and only while a slot is free, so a push can never overflow.
    assign mem.memReq  = !rst && !r_outst && (r_count < CW'(DEPTH)) && !brTaken;
    assign mem.memAddr = r_fpc;

    assign w_accept = mem.memReq && mem.memReady;
    assign w_push   = mem.memRvalid && r_outst && !r_discard && !brTaken;
    assign w_pop    = valid && !freeze && !brTaken;

    assign valid       = (r_count != '0);
    assign PC          = valid ? r_abuf[r_rptr] : '0;
    assign instruction = valid ? r_dbuf[r_rptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpc     <= RESET_PC;
            r_oaddr   <= '0;
            r_outst   <= 1'b0;
            r_discard <= 1'b0;
            r_rptr    <= '0;
            r_wptr    <= '0;
            r_count   <= '0;
        end else if (brTaken) begin
            r_fpc   <= w_target;
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            // A response landing with the branch is dropped here; otherwise the next one is.
            if (mem.memRvalid) begin
                r_outst   <= 1'b0;
                r_discard <= 1'b0;
            end else begin
                r_discard <= r_outst;
            end
        end else begin
            if (w_accept) begin
                r_fpc   <= r_fpc + ADDR_WIDTH'(4);
                r_oaddr <= r_fpc;
                r_outst <= 1'b1;
            end
            if (mem.memRvalid && r_outst) begin
                r_outst   <= 1'b0;
                r_discard <= 1'b0;
            end
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_abuf[r_wptr] <= r_oaddr;
            r_dbuf[r_wptr] <= mem.memRdata;
        end
    end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: sequencing, freeze credit, branch flush,
// reset mid-request, address wrap (8-bit instance) and a randomized in-order run.
module tb_if_prefetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        brTaken = 1'b0;
    logic        freeze = 1'b0;
    logic [31:0] brBase = '0;
    logic [31:0] brOffset = '0;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        valid;
    logic [7:0]  PC8;
    logic [31:0] instr8;
    logic        valid8;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    bit rand_lat = 1'b0;
    int accept_cnt = 0;
    logic        rv_busy = 1'b0;
    int          rv_cnt = 0;
    logic [31:0] rv_addr = '0;

    always #5 clk = ~clk;

    if_prefetch_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mi ();
    if_prefetch_stage_if #(.ADDR_WIDTH(8),  .DATA_WIDTH(32)) mi8 ();

    if_prefetch_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .brTaken(brTaken), .brBase(brBase), .brOffset(brOffset),
        .freeze(freeze), .mem(mi), .PC(PC), .instruction(instruction), .valid(valid)
    );

    if_prefetch_stage #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(8'hF8)) dut8 (
        .clk(clk), .rst(rst), .brTaken(1'b0), .brBase(8'h00), .brOffset(8'h00),
        .freeze(1'b0), .mem(mi8), .PC(PC8), .instruction(instr8), .valid(valid8)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    // Memory model: fixed or random 1-4 cycle latency, one request at a time.
    always @(posedge clk) begin
        int l;
        mi.memRvalid <= 1'b0;
        if (rv_busy) begin
            if (rv_cnt <= 1) begin
                mi.memRvalid <= 1'b1;
                mi.memRdata  <= memf(rv_addr);
                rv_busy      <= 1'b0;
            end else begin
                rv_cnt <= rv_cnt - 1;
            end
        end else if (mi.memReq && mi.memReady) begin
            accept_cnt <= accept_cnt + 1;
            l = rand_lat ? int'($urandom_range(4, 1)) : lat;
            if (l == 1) begin
                mi.memRvalid <= 1'b1;
                mi.memRdata  <= memf(mi.memAddr);
            end else begin
                rv_busy <= 1'b1;
                rv_cnt  <= l - 1;
                rv_addr <= mi.memAddr;
            end
        end
    end

    assign mi8.memReady = 1'b1;
    always @(posedge clk) begin
        mi8.memRvalid <= mi8.memReq && mi8.memReady;
        mi8.memRdata  <= memf({24'h0, mi8.memAddr});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (valid !== 1'b1 && n < 50);
        chk("wait_valid", 32'(valid), 32'd1);
    endtask

    // Holds reset long enough for any stale response to drain, then releases at a negedge.
    task automatic do_reset(input int l, input bit f);
        @(negedge clk);
        mi.memReady = 1'b0;
        rst = 1'b1;
        brTaken = 1'b0;
        freeze = f;
        lat = l;
        repeat (6) @(negedge clk);
        mi.memReady = 1'b1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int pops;
        logic [31:0] e;
        logic [7:0] pc8_tab [4];
        pc8_tab = '{8'hF8, 8'hFC, 8'h00, 8'h04};
        mi.memReady = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc", PC, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_memReq", 32'(mi.memReq), 32'd0);
        chk("rst_valid8", 32'(valid8), 32'd0);

        // Sequential fetch, plus the 8-bit instance wrapping past 0xFC.
        do_reset(1, 1'b0);
        wait_valid(n);
        chk("first_latency", n, 32'd2);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) wait_valid(n);
            e = 32'(4 * k);
            chk("seq_pc", PC, e);
            chk("seq_instr", instruction, memf(e));
            chk("wrap_valid8", 32'(valid8), 32'd1);
            chk("wrap_pc8", 32'(PC8), 32'(pc8_tab[k]));
            chk("wrap_instr8", instr8, memf({24'h0, pc8_tab[k]}));
        end

        // Freeze: fill to DEPTH, head held, then drain on consecutive cycles.
        do_reset(1, 1'b1);
        base = accept_cnt;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (valid) chk("frz_pc", PC, 32'd0);
        end
        chk("frz_accepts", 32'(accept_cnt - base), 32'd4);
        chk("frz_memReq", 32'(mi.memReq), 32'd0);
        chk("frz_valid", 32'(valid), 32'd1);
        freeze = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk("drain_valid", 32'(valid), 32'd1);
            chk("drain_pc", PC, 32'(4 * k));
        end

        // Branch with a request in flight: flush and drop the late response.
        do_reset(3, 1'b1);
        wait_valid(n);
        chk("lat3_latency", n, 32'd4);
        chk("lat3_pc", PC, 32'd0);
        @(negedge clk);
        chk("br_pre_valid", 32'(valid), 32'd1);
        brTaken = 1'b1;
        brBase = 32'h20;
        brOffset = 32'hFFFF_FFFE;
        #1;
        chk("br_memReq", 32'(mi.memReq), 32'd0);
        @(negedge clk);
        brTaken = 1'b0;
        #1;
        chk("br_flush_valid", 32'(valid), 32'd0);
        chk("br_flush_pc", PC, 32'd0);
        chk("br_discard_memReq", 32'(mi.memReq), 32'd0);
        freeze = 1'b0;
        wait_valid(n);
        chk("br_target_pc", PC, 32'h18);
        chk("br_target_instr", instruction, memf(32'h18));

        // Branch colliding with freeze and a response: flush wins.
        do_reset(1, 1'b1);
        @(negedge clk);
        chk("col_rvalid", 32'(mi.memRvalid), 32'd1);
        brTaken = 1'b1;
        brBase = 32'h100;
        brOffset = 32'h4;
        @(negedge clk);
        brTaken = 1'b0;
        #1;
        chk("col_valid", 32'(valid), 32'd0);
        chk("col_memReq", 32'(mi.memReq), 32'd1);
        chk("col_memAddr", mi.memAddr, 32'h110);
        wait_valid(n);
        chk("col_pc", PC, 32'h110);

        // Reset while a request is outstanding: the stale response is ignored.
        do_reset(3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_memReq", 32'(mi.memReq), 32'd0);
        @(negedge clk);
        mi.memReady = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stale_valid", 32'(valid), 32'd0);
        end
        mi.memReady = 1'b1;
        wait_valid(n);
        chk("post_rst_pc", PC, 32'd0);
        chk("post_rst_instr", instruction, memf(32'd0));

        // Random ready, latency and freeze: every popped entry must be the next PC.
        rand_lat = 1'b1;
        do_reset(1, 1'b0);
        e = '0;
        pops = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            freeze = ($urandom_range(3, 0) == 0);
            mi.memReady = ($urandom_range(1, 0) == 1);
            if (valid && !freeze) begin
                chk("rnd_pc", PC, e);
                chk("rnd_instr", instruction, memf(e));
                e = e + 32'd4;
                pops++;
            end
        end
        chk("rnd_progress", 32'(pops >= 40), 32'd1);
        rand_lat = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
